stage4_memory_bus: RTL and testbench



---
 rtl/stage4_memory_bus.sv | 166 ++++++++++++++++
 tb/tb_stage4_memory_bus.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stage4_memory_bus.sv
// Pipeline stage 4: request/acknowledge data-bus access (byte/half/word, sign/zero extend, misalign check).
// Non-mem latency 1 cycle, mem latency >= 2 cycles; stall_o holds upstream while a bus access is outstanding.
module stage4_memory_bus #(
    parameter int ADDR_WIDTH     = 30,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               alu_i,
    input  logic [31:0]               store_data_i,
    input  logic                      control_load_i,
    input  logic                      control_store_i,
    input  logic [1:0]                size_i,
    input  logic                      load_signed_i,
    input  logic                      control_take_branch_i,
    input  logic                      do_wb_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_reg_i,
    output logic                      stall_o,
    output logic                      take_branch_o,
    output logic [ADDR_WIDTH-1:0]     branch_pc_o,
    output logic                      misalign_o,
    output logic                      dbus_req_o,
    output logic                      dbus_we_o,
    output logic [ADDR_WIDTH-1:0]     dbus_addr_o,
    output logic [3:0]                dbus_be_o,
    output logic [31:0]               dbus_wdata_o,
    input  logic [31:0]               dbus_rdata_i,
    input  logic                      dbus_ack_i,
    output logic                      do_wb_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_o,
    output logic [31:0]               wb_val_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                    state_q;
    logic [ADDR_WIDTH-1:0]     alu_q;
    logic [1:0]                size_q;
    logic                      signed_q;
    logic                      load_q;
    logic                      do_wb_r_q;
    logic                      take_branch_q;
    logic                      misalign_q;
    logic                      dbus_req_q;
    logic                      dbus_we_q;
    logic [ADDR_WIDTH-1:0]     dbus_addr_q;
    logic [3:0]                dbus_be_q;
    logic [31:0]               dbus_wdata_q;
    logic                      do_wb_q;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_q;
    logic [31:0]               wb_val_q;

    logic        mem_op_d;
    logic        misalign_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [15:0] lane_d;
    logic [31:0] load_val_d;

    always_comb begin
        mem_op_d   = control_load_i | control_store_i;
        misalign_d = mem_op_d & (((size_i == 2'b01) & alu_i[0]) |
                                 (size_i[1] & (alu_i[1:0] != 2'b00)));
        be_d       = 4'b1111;
        wdata_d    = store_data_i;
        case (size_i)
            2'b00: begin
                be_d    = 4'b0001 << alu_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << alu_i[1:0];
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the captured byte offset; halves are aligned so the shift lands on 0 or 16.
    always_comb begin
        lane_d     = 16'(dbus_rdata_i >> {alu_q[1:0], 3'b000});
        load_val_d = dbus_rdata_i;
        case (size_q)
            2'b00:   load_val_d = signed_q ? {{24{lane_d[7]}}, lane_d[7:0]} : {24'h0, lane_d[7:0]};
            2'b01:   load_val_d = signed_q ? {{16{lane_d[15]}}, lane_d} : {16'h0, lane_d};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            alu_q         <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            load_q        <= 1'b0;
            do_wb_r_q     <= 1'b0;
            take_branch_q <= 1'b0;
            misalign_q    <= 1'b0;
            dbus_req_q    <= 1'b0;
            dbus_we_q     <= 1'b0;
            dbus_addr_q   <= '0;
            dbus_be_q     <= '0;
            dbus_wdata_q  <= '0;
            do_wb_q       <= 1'b0;
            wb_reg_q      <= '0;
            wb_val_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    alu_q         <= alu_i[ADDR_WIDTH-1:0];
                    size_q        <= size_i;
                    signed_q      <= load_signed_i;
                    load_q        <= control_load_i;
                    do_wb_r_q     <= do_wb_i;
                    take_branch_q <= control_take_branch_i;
                    wb_reg_q      <= wb_reg_i;
                    misalign_q    <= 1'b0;
                    if (!mem_op_d) begin
                        do_wb_q  <= do_wb_i;
                        wb_val_q <= alu_i;
                    end else if (misalign_d) begin
                        misalign_q <= 1'b1;
                        do_wb_q    <= 1'b0;
                    end else begin
                        do_wb_q      <= 1'b0;
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= ~control_load_i;
                        dbus_addr_q  <= alu_i[ADDR_WIDTH+1:2];
                        dbus_be_q    <= be_d;
                        dbus_wdata_q <= wdata_d;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    take_branch_q <= 1'b0;
                    misalign_q    <= 1'b0;
                    do_wb_q       <= 1'b0;
                    if (dbus_ack_i) begin
                        dbus_req_q <= 1'b0;
                        state_q    <= IDLE;
                        if (load_q) begin
                            do_wb_q  <= do_wb_r_q;
                            wb_val_q <= load_val_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_o       = (state_q == ACCESS);
    assign take_branch_o = take_branch_q;
    assign branch_pc_o   = alu_q;
    assign misalign_o    = misalign_q;
    assign dbus_req_o    = dbus_req_q;
    assign dbus_we_o     = dbus_we_q;
    assign dbus_addr_o   = dbus_addr_q;
    assign dbus_be_o     = dbus_be_q;
    assign dbus_wdata_o  = dbus_wdata_q;
    assign do_wb_o       = do_wb_q;
    assign wb_reg_o      = wb_reg_q;
    assign wb_val_o      = wb_val_q;

endmodule

// File: tb/tb_stage4_memory_bus.sv
// Directed bench for stage4_memory_bus: hand-computed vectors, outputs sampled 1ns after the rising edge.
module tb_stage4_memory_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu, sd, rdata;
    logic        ld, st, sgn, tb_br, do_wb, ack;
    logic [1:0]  size;
    logic [3:0]  wb_reg;
    logic        stall, take_br, misalign, req, we, do_wb_out;
    logic [29:0] br_pc, addr;
    logic [3:0]  be, wb_reg_out;
    logic [31:0] wdata, wb_val;

    int n_checks = 0;
    int n_fail   = 0;

    stage4_memory_bus #(.ADDR_WIDTH(30), .REG_ADDR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .alu_i(alu), .store_data_i(sd),
        .control_load_i(ld), .control_store_i(st), .size_i(size),
        .load_signed_i(sgn), .control_take_branch_i(tb_br), .do_wb_i(do_wb),
        .wb_reg_i(wb_reg), .stall_o(stall), .take_branch_o(take_br),
        .branch_pc_o(br_pc), .misalign_o(misalign), .dbus_req_o(req),
        .dbus_we_o(we), .dbus_addr_o(addr), .dbus_be_o(be), .dbus_wdata_o(wdata),
        .dbus_rdata_i(rdata), .dbus_ack_i(ack), .do_wb_o(do_wb_out),
        .wb_reg_o(wb_reg_out), .wb_val_o(wb_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu = 0; sd = 0; ld = 0; st = 0; size = 0; sgn = 0;
        tb_br = 0; do_wb = 0; wb_reg = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1; ack = 0; rdata = 0;
        step(); step();
        check("rst_stall", 32'(stall), 0);
        check("rst_req", 32'(req), 0);
        check("rst_dowb", 32'(do_wb_out), 0);
        check("rst_wbval", wb_val, 0);
        check("rst_brpc", 32'(br_pc), 0);
        check("rst_misalign", 32'(misalign), 0);
        rst = 0;

        // Non-memory writeback
        alu = 32'h1234; do_wb = 1; wb_reg = 3;
        step();
        idle_inputs();
        check("nm_dowb", 32'(do_wb_out), 1);
        check("nm_wbreg", 32'(wb_reg_out), 3);
        check("nm_wbval", wb_val, 32'h1234);
        check("nm_stall", 32'(stall), 0);
        step();
        check("nm_dowb_pulse", 32'(do_wb_out), 0);

        // Ack while idle must do nothing
        ack = 1; rdata = 32'hFFFF_FFFF;
        step();
        ack = 0;
        check("idle_ack_req", 32'(req), 0);
        check("idle_ack_stall", 32'(stall), 0);

        // Signed byte load, ack sampled on the third edge after issue
        alu = 32'h103; ld = 1; size = 2'b00; sgn = 1; do_wb = 1; wb_reg = 5;
        step();
        alu = 32'hFFFF; ld = 0; sgn = 0; do_wb = 0; wb_reg = 9;
        check("lb_req", 32'(req), 1);
        check("lb_we", 32'(we), 0);
        check("lb_addr", 32'(addr), 32'h40);
        check("lb_be", 32'(be), 32'h8);
        check("lb_stall1", 32'(stall), 1);
        step();
        check("lb_stall2", 32'(stall), 1);
        check("lb_addr_hold", 32'(addr), 32'h40);
        step();
        check("lb_stall3", 32'(stall), 1);
        ack = 1; rdata = 32'h80FF_0000;
        step();
        ack = 0;
        check("lb_stall_done", 32'(stall), 0);
        check("lb_req_drop", 32'(req), 0);
        check("lb_dowb", 32'(do_wb_out), 1);
        check("lb_wbreg", 32'(wb_reg_out), 5);
        check("lb_wbval", wb_val, 32'hFFFF_FF80);
        step();
        idle_inputs();
        check("lb_dowb_pulse", 32'(do_wb_out), 0);
        check("lb_next_wbval", wb_val, 32'hFFFF);

        // Unsigned upper-half load, minimum latency
        alu = 32'h12; ld = 1; size = 2'b01; sgn = 0; do_wb = 1; wb_reg = 7;
        step();
        idle_inputs();
        check("lhu_be", 32'(be), 32'hC);
        check("lhu_addr", 32'(addr), 32'h4);
        ack = 1; rdata = 32'h8765_4321;
        step();
        ack = 0;
        check("lhu_dowb", 32'(do_wb_out), 1);
        check("lhu_wbval", wb_val, 32'h0000_8765);

        // Store half to upper lane
        alu = 32'h202; sd = 32'h1234_ABCD; st = 1; size = 2'b01; do_wb = 1;
        step();
        idle_inputs();
        check("sh_we", 32'(we), 1);
        check("sh_be", 32'(be), 32'hC);
        check("sh_wdata", wdata, 32'hABCD_ABCD);
        check("sh_addr", 32'(addr), 32'h80);
        check("sh_dowb_issue", 32'(do_wb_out), 0);
        ack = 1;
        step();
        ack = 0;
        check("sh_dowb_ack", 32'(do_wb_out), 0);
        check("sh_stall", 32'(stall), 0);
        check("sh_wbval_kept", wb_val, 32'h0000_8765);

        // Store byte lane replication
        alu = 32'h301; sd = 32'hFFFF_FF5A; st = 1; size = 2'b00;
        step();
        idle_inputs();
        check("sb_be", 32'(be), 32'h2);
        check("sb_wdata", wdata, 32'h5A5A_5A5A);
        ack = 1;
        step();
        ack = 0;

        // Load and store together behave as a load (word)
        alu = 32'h8; ld = 1; st = 1; size = 2'b10; sgn = 1; do_wb = 1; wb_reg = 2;
        step();
        idle_inputs();
        check("ldst_we", 32'(we), 0);
        check("ldst_be", 32'(be), 32'hF);
        ack = 1; rdata = 32'hDEAD_BEEF;
        step();
        ack = 0;
        check("ldst_wbval", wb_val, 32'hDEAD_BEEF);
        check("ldst_dowb", 32'(do_wb_out), 1);

        // Misaligned word
        alu = 32'h5; ld = 1; size = 2'b10; do_wb = 1;
        step();
        idle_inputs();
        check("mis_pulse", 32'(misalign), 1);
        check("mis_req", 32'(req), 0);
        check("mis_dowb", 32'(do_wb_out), 0);
        check("mis_stall", 32'(stall), 0);
        step();
        check("mis_pulse_end", 32'(misalign), 0);

        // Misaligned half
        alu = 32'h7; st = 1; size = 2'b01;
        step();
        idle_inputs();
        check("mish_pulse", 32'(misalign), 1);
        check("mish_req", 32'(req), 0);
        step();

        // Branch
        alu = 32'h40; tb_br = 1;
        step();
        idle_inputs();
        check("br_take", 32'(take_br), 1);
        check("br_pc", 32'(br_pc), 32'h40);
        step();
        check("br_take_end", 32'(take_br), 0);

        // Reset in the middle of an access
        alu = 32'h100; ld = 1; size = 2'b10; do_wb = 1; wb_reg = 4;
        step();
        idle_inputs();
        check("rma_stall", 32'(stall), 1);
        rst = 1;
        step();
        rst = 0;
        check("rma_req", 32'(req), 0);
        check("rma_stall_clr", 32'(stall), 0);
        check("rma_be", 32'(be), 0);
        check("rma_addr", 32'(addr), 0);
        check("rma_wbval", wb_val, 0);
        ack = 1; rdata = 32'h5555_5555;
        step();
        ack = 0;
        check("rma_late_dowb", 32'(do_wb_out), 0);
        check("rma_late_wbval", wb_val, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
